// File: rtl/lcd_line_buffer.sv
// lcd_line_buffer: byte-stream line editor feeding the 16-char LCD driver.
// A working line is edited at a cursor (printables, CR, BS, FF) and LF commits
// a snapshot to line_out, followed by a sequential clear of the working line.
// Optional feature macro: LCD_LINE_AUTOWRAP_EN. When it is defined, a printable
// byte arriving on a full line auto-commits and wraps to index 0 of the next line.
module lcd_line_buffer #(
  parameter int         NCHARS    = 16,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  localparam int        CW        = $clog2(NCHARS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ch_valid,
  input  logic [7:0]          ch_data,
  output logic                ch_ready,
  output logic [8*NCHARS-1:0] line_out,
  output logic                line_update,
  output logic [CW-1:0]       cursor,
  output logic                overflow
);

  localparam int             IW       = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam logic [CW-1:0]  CUR_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CUR_ONE  = CW'(1);
  localparam logic [CW-1:0]  CUR_MAX  = CW'(NCHARS);
  localparam logic [IW-1:0]  IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NCHARS - 1);

`ifdef LCD_LINE_AUTOWRAP_EN
  typedef enum logic [1:0] {ST_ACCEPT = 2'd0, ST_CLEAR = 2'd1, ST_WRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_ACCEPT = 2'd0, ST_CLEAR = 2'd1} state_t;
`endif

  state_t                state_r;
  logic [7:0]            buf_r [NCHARS];
  logic [8*NCHARS-1:0]   line_out_r;
  logic                  line_update_r;
  logic [CW-1:0]         cursor_r;
  logic                  overflow_r;
  logic [IW-1:0]         clr_idx_r;
`ifdef LCD_LINE_AUTOWRAP_EN
  logic [7:0]            held_r;
  logic                  wrap_pend_r;
`endif

  logic                  is_print_s;
  logic [IW-1:0]         wr_idx_s;
  logic [IW-1:0]         bs_idx_s;
  logic [8*NCHARS-1:0]   pack_s;

  assign is_print_s = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
  assign wr_idx_s   = cursor_r[IW-1:0];
  assign bs_idx_s   = cursor_r[IW-1:0] - IDX_ONE;

  // Flatten the working buffer into line_out layout (char 0 in the top byte).
  always_comb begin
    pack_s = {(8*NCHARS){1'b0}};
    for (int i = 0; i < NCHARS; i++) begin
      pack_s[(NCHARS-1-i)*8 +: 8] = buf_r[i];
    end
  end

  // Control FSM together with working buffer, cursor, commit and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_ACCEPT;
      for (int i = 0; i < NCHARS; i++) begin
        buf_r[i] <= FILL_CHAR;
      end
      line_out_r    <= {NCHARS{FILL_CHAR}};
      line_update_r <= 1'b0;
      cursor_r      <= CUR_ZERO;
      overflow_r    <= 1'b0;
      clr_idx_r     <= IDX_ZERO;
`ifdef LCD_LINE_AUTOWRAP_EN
      held_r        <= FILL_CHAR;
      wrap_pend_r   <= 1'b0;
`endif
    end else begin
      line_update_r <= 1'b0;
      case (state_r)
        ST_ACCEPT: begin
          if (ch_valid) begin
            if (is_print_s) begin
              if (cursor_r < CUR_MAX) begin
                buf_r[wr_idx_s] <= ch_data;
                cursor_r        <= cursor_r + CUR_ONE;
              end else begin
`ifdef LCD_LINE_AUTOWRAP_EN
                // Full line: commit like LF and carry the byte into the next line.
                held_r        <= ch_data;
                line_out_r    <= pack_s;
                line_update_r <= 1'b1;
                cursor_r      <= CUR_ZERO;
                state_r       <= ST_WRAP;
`else
                overflow_r    <= 1'b1;
`endif
              end
            end else begin
              case (ch_data)
                8'h0A: begin
                  line_out_r    <= pack_s;
                  line_update_r <= 1'b1;
                  overflow_r    <= 1'b0;
                  cursor_r      <= CUR_ZERO;
                  clr_idx_r     <= IDX_ZERO;
                  state_r       <= ST_CLEAR;
                end
                8'h0D: begin
                  cursor_r <= CUR_ZERO;
                end
                8'h08: begin
                  if (cursor_r != CUR_ZERO) begin
                    cursor_r        <= cursor_r - CUR_ONE;
                    buf_r[bs_idx_s] <= FILL_CHAR;
                  end
                end
                8'h0C: begin
                  cursor_r  <= CUR_ZERO;
                  clr_idx_r <= IDX_ZERO;
                  state_r   <= ST_CLEAR;
                end
                default: begin
                  // Non-printable, non-control bytes are consumed without effect.
                end
              endcase
            end
          end
        end
        ST_CLEAR: begin
          buf_r[clr_idx_r] <= FILL_CHAR;
          if (clr_idx_r == IDX_LAST) begin
            clr_idx_r <= IDX_ZERO;
            state_r   <= ST_ACCEPT;
`ifdef LCD_LINE_AUTOWRAP_EN
            if (wrap_pend_r) begin
              buf_r[0]    <= held_r;
              cursor_r    <= CUR_ONE;
              wrap_pend_r <= 1'b0;
            end
`endif
          end else begin
            clr_idx_r <= clr_idx_r + IDX_ONE;
          end
        end
`ifdef LCD_LINE_AUTOWRAP_EN
        ST_WRAP: begin
          clr_idx_r   <= IDX_ZERO;
          wrap_pend_r <= 1'b1;
          state_r     <= ST_CLEAR;
        end
`endif
        default: begin
          state_r <= ST_ACCEPT;
        end
      endcase
    end
  end

  assign ch_ready    = (state_r == ST_ACCEPT);
  assign line_out    = line_out_r;
  assign line_update = line_update_r;
  assign cursor      = cursor_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_lcd_line_buffer.sv
// Directed bench for lcd_line_buffer (default build, auto-wrap disabled).
module tb_lcd_line_buffer;

  logic         clk;
  logic         rst_n;
  logic         ch_valid;
  logic [7:0]   ch_data;
  logic         ch_ready;
  logic [127:0] line_out;
  logic         line_update;
  logic [4:0]   cursor;
  logic         overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] model_buf [16];
  int         model_cur;

  lcd_line_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ch_ready    (ch_ready),
    .line_out    (line_out),
    .line_update (line_update),
    .cursor      (cursor),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; waits for ready, then presents one byte for one edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (!ch_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total_cnt++;
      $error("FAIL send_timeout: observed ch_ready=0 after %0d cycles, expected 1", n);
    end
    ch_valid = 1'b1;
    ch_data  = b;
    @(negedge clk);
    ch_valid = 1'b0;
    ch_data  = 8'h00;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ch_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total_cnt++;
      $error("FAIL ready_timeout: observed ch_ready=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (model_cur < 16) begin
        model_buf[model_cur] = b;
        model_cur++;
      end
    end else if (b == 8'h0D) begin
      model_cur = 0;
    end else if (b == 8'h08) begin
      if (model_cur > 0) begin
        model_cur--;
        model_buf[model_cur] = 8'h20;
      end
    end
  endtask

  function automatic logic [127:0] model_line();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[(15-i)*8 +: 8] = model_buf[i];
    return r;
  endfunction

  initial begin
    int n;
    int upd;
    logic [7:0] pool [6];
    logic [7:0] b;

    ch_valid = 1'b0;
    ch_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state, then "HELLO\n"
    check("rst_line_out", line_out, {16{8'h20}});
    check("rst_cursor", cursor, 5'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_update", line_update, 1'b0);
    check("rst_ready", ch_ready, 1'b1);
    send("H"); send("E"); send("L"); send("L"); send("O");
    check("hello_cursor", cursor, 5'd5);
    check("hello_no_commit", line_out, {16{8'h20}});
    send(8'h0A);
    check("hello_line", line_out, {"HELLO", {11{8'h20}}});
    check("hello_update", line_update, 1'b1);
    check("hello_cursor0", cursor, 5'd0);
    n = 0;
    upd = 0;
    while (!ch_ready && n < 40) begin
      if (line_update) upd++;
      n++;
      @(negedge clk);
    end
    check("clear_busy_cycles", n, 16);
    check("update_pulse_count", upd, 1);
    check("after_clear_update", line_update, 1'b0);

    // 2: BS at cursor 0 is a no-op, then "ABC" BS BS "Z" LF
    send(8'h08);
    check("bs_at_zero", cursor, 5'd0);
    send("A"); send("B"); send("C"); send(8'h08); send(8'h08);
    check("bs_cursor", cursor, 5'd1);
    send("Z"); send(8'h0A);
    check("bs_line", line_out, {"AZ", {14{8'h20}}});
    wait_ready();

    // 3: 17 printables then LF
    for (int i = 0; i < 16; i++) send(8'h41 + 8'(i));
    check("full_cursor", cursor, 5'd16);
    check("full_no_overflow", overflow, 1'b0);
    send("Q");
    check("overflow_set", overflow, 1'b1);
    check("overflow_cursor", cursor, 5'd16);
    send(8'h0A);
    check("full_line", line_out, "ABCDEFGHIJKLMNOP");
    check("overflow_cleared", overflow, 1'b0);
    wait_ready();

    // 4: CR overwrite, then FF + LF yields a blank line
    send("X"); send("Y"); send("Z"); send(8'h0D); send("A"); send("B"); send(8'h0A);
    check("cr_line", line_out, {"ABZ", {13{8'h20}}});
    wait_ready();
    send("J"); send(8'h0C);
    check("ff_no_update", line_update, 1'b0);
    check("ff_ready_low", ch_ready, 1'b0);
    check("ff_line_kept", line_out, {"ABZ", {13{8'h20}}});
    wait_ready();
    send(8'h0A);
    check("ff_blank_line", line_out, {16{8'h20}});
    wait_ready();

    // 5: reset in the middle of CLEAR with ch_valid held
    send("Q"); send("Q"); send(8'h0A);
    wait_ready();
    for (int i = 0; i < 17; i++) send("w");
    send(8'h0C);
    check("ff_overflow_kept", overflow, 1'b1);
    check("ff_line_kept2", line_out, {"QQ", {14{8'h20}}});
    repeat (3) @(negedge clk);
    rst_n    = 1'b0;
    ch_valid = 1'b1;
    ch_data  = 8'h41;
    @(negedge clk);
    check("midrst_line", line_out, {16{8'h20}});
    check("midrst_cursor", cursor, 5'd0);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_update", line_update, 1'b0);
    rst_n    = 1'b1;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    @(negedge clk);
    check("midrst_ready", ch_ready, 1'b1);
    check("midrst_no_update", line_update, 1'b0);
    check("midrst_cursor_after", cursor, 5'd0);

    // 6: random gaps and ignored bytes against a model
    pool[0] = 8'h00; pool[1] = 8'h7F; pool[2] = 8'h08;
    pool[3] = 8'h0D; pool[4] = 8'h4D; pool[5] = 8'h7E;
    for (int i = 0; i < 16; i++) model_buf[i] = 8'h20;
    model_cur = 0;
    for (int i = 0; i < 14; i++) begin
      if ((i % 3) == 0) b = 8'h61 + 8'(i);
      else b = pool[$urandom_range(0, 5)];
      model_byte(b);
      send(b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rand_cursor", cursor, 5'(model_cur));
    end
    send(8'h00);
    check("ignored_no_update", line_update, 1'b0);
    send(8'h7F);
    check("ignored_cursor", cursor, 5'(model_cur));
    send(8'h0A);
    check("rand_line", line_out, model_line());
    wait_ready();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
